// File: rtl/bit_scan_pkg.sv
// Shared definitions for the bit scan encoder: FSM state encoding and index-width helper.
// Pure declarations; no logic, no latency.
package bit_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_ZERO = 2'd2
    } state_e;

    // Minimum bits needed to address 'value' positions (value >= 2).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pri_enc_w.sv
// Combinational priority encoder: index of the first set bit (MSB- or LSB-first),
// plus exactly-one and any-set flags. Zero latency, no flow control.
module pri_enc_w
    import bit_scan_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 0,
    localparam int IDXW     = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDXW-1:0]  idx_o,
    output logic             one_o,
    output logic             any_o
);

    always_comb begin
        idx_o = '0;
        if (LSB_FIRST != 0) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (vec_i[i]) idx_o = IDXW'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (vec_i[i]) idx_o = IDXW'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero only for single-bit vectors.
    assign any_o = |vec_i;
    assign one_o = any_o && ((vec_i & (vec_i - WIDTH'(1))) == '0);

endmodule

// File: rtl/bit_scan_encoder.sv
// Captures a vector, then emits one beat per set bit (priority order) or a single zero beat.
// First beat the cycle after capture; out_ready low stalls with all fields held; in_ready only in IDLE.
module bit_scan_encoder
    import bit_scan_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 0,
    localparam int IDXW     = clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDXW-1:0]   out_idx,
    output logic [IDXW:0]     out_count,
    output logic              out_last,
    output logic              out_zero
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [IDXW:0]      count_q, count_d;
    logic [IDXW:0]      in_pop;
    logic [IDXW-1:0]    enc_idx;
    logic               enc_one;
    logic               enc_any;

    pri_enc_w #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_pri_enc (
        .vec_i (work_q),
        .idx_o (enc_idx),
        .one_o (enc_one),
        .any_o (enc_any)
    );

    // Ones count is taken once at capture and held for every beat of the vector.
    always_comb begin
        in_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            in_pop = in_pop + (IDXW+1)'(in_vec[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d  = in_vec;
                    count_d = in_pop;
                    state_d = (|in_vec) ? ST_SCAN : ST_ZERO;
                end
            end
            ST_SCAN: begin
                if (out_ready) begin
                    work_d = work_q & ~(WIDTH'(1) << enc_idx);
                    if (enc_one || !enc_any) begin
                        state_d = ST_IDLE;
                        count_d = '0;
                    end
                end
            end
            ST_ZERO: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                work_d  = '0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            count_q <= count_d;
        end
    end

    // Outputs decode registered state only, so nothing is combinational from the inputs.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_idx   = '0;
        out_count = '0;
        out_last  = 1'b0;
        out_zero  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_SCAN: begin
                out_valid = 1'b1;
                out_idx   = enc_idx;
                out_count = count_q;
                out_last  = enc_one;
            end
            ST_ZERO: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_zero  = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bit_scan_encoder.sv
// Bench: directed and random vectors on an 8-bit MSB-first and a 16-bit LSB-first instance,
// each beat compared against an index list built straight from the vector's set bits.
module tb_bit_scan_encoder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_in_valid, b_in_valid;
    logic [15:0] in_vec;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_last, a_out_zero;
    logic [2:0]  a_out_idx;
    logic [3:0]  a_out_count;
    logic        b_in_ready, b_out_valid, b_out_last, b_out_zero;
    logic [3:0]  b_out_idx;
    logic [4:0]  b_out_count;

    bit_scan_encoder #(.WIDTH(8), .LSB_FIRST(0)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_vec    (in_vec[7:0]),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .out_idx   (a_out_idx),
        .out_count (a_out_count),
        .out_last  (a_out_last),
        .out_zero  (a_out_zero)
    );

    bit_scan_encoder #(.WIDTH(16), .LSB_FIRST(1)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_vec    (in_vec),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .out_idx   (b_out_idx),
        .out_count (b_out_count),
        .out_last  (b_out_last),
        .out_zero  (b_out_zero)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   sel      = 1'b0;

    logic       o_in_rdy, o_vld, o_last, o_zero;
    logic [3:0] o_idx;
    logic [4:0] o_cnt;

    always_comb begin
        o_in_rdy = sel ? b_in_ready  : a_in_ready;
        o_vld    = sel ? b_out_valid : a_out_valid;
        o_idx    = sel ? b_out_idx   : {1'b0, a_out_idx};
        o_cnt    = sel ? b_out_count : {1'b0, a_out_count};
        o_last   = sel ? b_out_last  : a_out_last;
        o_zero   = sel ? b_out_zero  : a_out_zero;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s (dut %0d, t=%0t): got %0h expected %0h", tag, sel, $time, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".in_ready"},  64'(o_in_rdy), 64'd1);
        chk({tag, ".out_valid"}, 64'(o_vld),    64'd0);
        chk({tag, ".out_idx"},   64'(o_idx),    64'd0);
        chk({tag, ".out_count"}, 64'(o_cnt),    64'd0);
        chk({tag, ".out_last"},  64'(o_last),   64'd0);
        chk({tag, ".out_zero"},  64'(o_zero),   64'd0);
    endtask

    task automatic set_valid(input logic v);
        if (sel) b_in_valid = v;
        else     a_in_valid = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected beats: set-bit positions in scan order, or a single index-0 beat for an empty vector.
    task automatic run_vec(input logic [15:0] vec, input logic [31:0] pat, input int pat_len,
                           input bit rnd_rdy, input bit poke);
        int   w;
        int   q[$];
        int   beats;
        int   cyc;
        int   guard;
        bit   zv;
        logic rdy;
        w = sel ? 16 : 8;
        if (sel) begin
            for (int i = 0; i < w; i++) if (vec[i]) q.push_back(i);
        end else begin
            for (int i = w - 1; i >= 0; i--) if (vec[i]) q.push_back(i);
        end
        zv = (q.size() == 0);
        if (zv) q.push_back(0);

        guard = 0;
        while (!o_in_rdy && guard < 20) begin
            tick();
            guard++;
        end
        chk("in_ready_before_capture", 64'(o_in_rdy), 64'd1);

        in_vec = vec;
        set_valid(1'b1);
        tick();
        set_valid(1'b0);

        beats = 0;
        cyc   = 0;
        while (beats < q.size() && cyc < 200) begin
            if (pat_len > 0) rdy = (cyc < pat_len) ? pat[cyc] : 1'b1;
            else             rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            chk("beat.out_valid", 64'(o_vld),    64'd1);
            chk("beat.in_ready",  64'(o_in_rdy), 64'd0);
            chk("beat.out_idx",   64'(o_idx),    64'(q[beats]));
            chk("beat.out_count", 64'(o_cnt),    zv ? 64'd0 : 64'(q.size()));
            chk("beat.out_last",  64'(o_last),   64'(beats == q.size() - 1));
            chk("beat.out_zero",  64'(o_zero),   64'(zv));
            if (poke) begin
                in_vec = 16'($urandom);
                set_valid(1'b1);
            end
            out_ready = rdy;
            tick();
            if (rdy) beats++;
            cyc++;
        end
        chk("beats_completed", 64'(beats), 64'(q.size()));
        set_valid(1'b0);
        out_ready = 1'b0;
        check_idle("bubble");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] v;
        rst        = 1'b1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        in_vec     = '0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        sel = 1'b0;
        check_idle("reset_a");
        sel = 1'b1;
        check_idle("reset_b");
        sel = 1'b0;

        run_vec(16'h0080, 32'd0, 0, 1'b0, 1'b0);
        run_vec(16'h00FF, 32'd0, 0, 1'b0, 1'b0);
        run_vec(16'h0000, 32'd0, 0, 1'b0, 1'b0);
        run_vec(16'h0025, 32'b110010, 6, 1'b0, 1'b1);

        // Reset in the middle of a scan: two beats taken, then everything discarded.
        in_vec = 16'h00FF;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        out_ready  = 1'b1;
        tick();
        tick();
        chk("pre_rst.out_idx", 64'(o_idx), 64'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("post_rst");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst.no_valid", 64'(o_vld), 64'd0);
        end
        out_ready = 1'b0;
        run_vec(16'h0002, 32'd0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            v = 16'($urandom) & 16'h00FF;
            if ($urandom_range(0, 5) == 0) v = '0;
            run_vec(v, 32'd0, 0, 1'b1, 1'($urandom_range(0, 1)));
        end

        sel = 1'b1;
        check_idle("b_idle");
        run_vec(16'h8011, 32'd0, 0, 1'b0, 1'b0);
        run_vec(16'h0000, 32'd0, 0, 1'b0, 1'b0);
        for (int n = 0; n < 20; n++) begin
            v = 16'($urandom);
            if ($urandom_range(0, 5) == 0) v = '0;
            run_vec(v, 32'd0, 0, 1'b1, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_scan_encoder.md
BIT_SCAN_ENCODER -- requirements
Module: bit_scan_encoder

Interface
REQ-001 Parameter WIDTH, default 8, width of input vector; legal range 2..64.
REQ-002 Parameter LSB_FIRST, default 0; 0 = scan highest set bit first, 1 = lowest set bit first.
REQ-003 Derived constant IDXW = clog2(WIDTH), width of the bit index.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  in_vec is valid this cycle.
REQ-007 in_ready  output  1  block can accept a vector this cycle.
REQ-008 in_vec  input  WIDTH  vector to scan.
REQ-009 out_valid  output  1  out_* fields valid this cycle.
REQ-010 out_ready  input  1  consumer accepts current beat.
REQ-011 out_idx  output  IDXW  index of current priority set bit.
REQ-012 out_count  output  IDXW+1  ones count of the captured vector, constant for all beats of one vector.
REQ-013 out_last  output  1  final beat for the captured vector.
REQ-014 out_zero  output  1  captured vector was all zeros.

Function
REQ-015 States: IDLE, SCAN, ZERO.
REQ-016 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready, capture in_vec into work register and its popcount into count register.
REQ-017 Capture transition: nonzero vector -> SCAN; zero vector -> ZERO.
REQ-018 SCAN: in_ready=0, out_valid=1; out_idx = priority set bit of work register per LSB_FIRST; out_last=1 iff work register holds exactly one set bit; out_zero=0.
REQ-019 SCAN beat accepted (out_valid&&out_ready): clear bit out_idx in work register; if out_last, go IDLE, else stay SCAN.
REQ-020 ZERO: out_valid=1, out_idx=0, out_count=0, out_last=1, out_zero=1, in_ready=0; on out_ready go IDLE.
REQ-021 Latency: first out_valid in the cycle after input acceptance; one index per cycle while out_ready held high.
REQ-022 Stall: while out_valid&&!out_ready, all out_* fields held stable.
REQ-023 in_ready depends on state register only; no combinational path from in_* or out_ready to any output.
REQ-024 out_idx, out_count, out_last, out_zero are 0 whenever out_valid=0.
REQ-025 in_valid while in_ready=0 is ignored; vector not captured, no error.
REQ-026 One idle bubble between last beat of a vector and acceptance of the next.
REQ-027 Total beats per vector = popcount when nonzero, 1 when zero.

Reset
REQ-028 rst high at a clock edge forces state IDLE, clears work and count registers, regardless of current state, including mid-scan.
REQ-029 Cycle after reset: in_ready=1, out_valid=0, all other outputs 0.
REQ-030 Beats in progress at reset are discarded; no out_valid pulse after reset until new input accepted.

Structure
REQ-031 Shared package/header bit_scan_pkg holds the state encoding constants and the clog2 function.
REQ-032 One sub-module pri_enc_w: combinational, parametrised WIDTH/LSB_FIRST priority encoder producing index, single-bit flag and any-set flag; instantiated on the work register.
REQ-033 Popcount computed once at capture, not re-derived per beat.

Verification (WIDTH=8 unless stated)
REQ-034 8'b1000_0000, out_ready=1 -> one beat: idx=7, count=1, last=1, zero=0; in_ready high again one cycle later.
REQ-035 8'b1111_1111, out_ready=1 -> idx 7,6,5,4,3,2,1,0 on 8 consecutive cycles, count=8 each beat, last only on idx 0.
REQ-036 8'b0000_0000 -> one beat: zero=1, idx=0, count=0, last=1.
REQ-037 8'b0010_0101, out_ready pattern 0,1,0,0,1,1 -> idx 5,5,2,2,2,0; fields stable while stalled; new in_valid during scan ignored.
REQ-038 8'b1111_1111, rst asserted after 2 accepted beats -> next cycle out_valid=0, in_ready=1; next vector 8'b0000_0010 yields single beat idx=1, count=1.
REQ-039 LSB_FIRST=1, WIDTH=16, 16'h8011 -> idx 0, 4, 15; count=3; last on idx 15.
